// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains a standard (1-cycle read latency) sync FIFO holding
// header+payload frames, strips each header and presents the payload as a
// valid/ready stream with m_last_o on the final word.
// Optional build macro: FIFO_FRAME_READER_STATS_EN adds frames_o, a 16-bit
// count of completed (non-empty) frames.
module fifo_frame_reader #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_LEN_WIDTH  = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    fifo_rd_o,
  input  logic [P_DATA_WIDTH-1:0] fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic                    m_valid_o,
  output logic [P_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  input  logic                    m_ready_i,
`ifdef FIFO_FRAME_READER_STATS_EN
  output logic [15:0]             frames_o,
`endif
  output logic                    busy_o
);

  typedef enum logic {S_HDR, S_PAY} state_t;

  localparam logic [P_LEN_WIDTH-1:0] LEN_ONE = P_LEN_WIDTH'(1);

  state_t                  state_q, state_d;
  logic                    in_flight_p1;
  logic [P_DATA_WIDTH-1:0] buf_p2 [2];
  logic                    head_p2;
  logic [1:0]              occ_p2;
  logic [P_LEN_WIDTH-1:0]  cnt_q, cnt_d;

  logic [P_DATA_WIDTH-1:0] head_word;
  logic [P_LEN_WIDTH-1:0]  hdr_len;
  logic                    have_head;
  logic                    pop;
  logic                    capture;
  logic                    tail_idx;
  logic [2:0]              pending;

  assign head_word = buf_p2[head_p2];
  assign hdr_len   = head_word[P_LEN_WIDTH-1:0];
  assign have_head = (occ_p2 != 2'd0);
  assign capture   = in_flight_p1;
  // Tail slot sits occ entries past the head; a capture never arrives with occ=2.
  assign tail_idx  = head_p2 ^ occ_p2[0];

  // Words already owned (buffered or returning) after this cycle's pop must
  // leave room for the word this read will return.
  assign pending   = {1'b0, occ_p2} + {2'b00, in_flight_p1} - {2'b00, pop};
  assign fifo_rd_o = !rst_i && !fifo_empty_i && (pending < 3'd2);

  assign m_data_o  = m_valid_o ? head_word : '0;
  assign busy_o    = (state_q == S_PAY) || have_head || in_flight_p1;

  // Frame FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_HDR;
    else       state_q <= state_d;
  end

  // Next-state, header strip, output handshake and length counter update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    case (state_q)
      S_HDR: begin
        if (have_head) begin
          pop = 1'b1;
          if (hdr_len != '0) begin
            cnt_d   = hdr_len;
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        m_valid_o = have_head;
        m_last_o  = have_head && (cnt_q == LEN_ONE);
        if (have_head && m_ready_i) begin
          pop   = 1'b1;
          cnt_d = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Stage p1: read issued last cycle, data returning on fifo_data_i now
  always_ff @(posedge clk_i) begin
    if (rst_i) in_flight_p1 <= 1'b0;
    else       in_flight_p1 <= fifo_rd_o;
  end

  // Stage p2: skid buffer bookkeeping and payload length counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_p2  <= 2'd0;
      head_p2 <= 1'b0;
      cnt_q   <= '0;
    end else begin
      occ_p2  <= occ_p2 + {1'b0, capture} - {1'b0, pop};
      head_p2 <= head_p2 ^ pop;
      cnt_q   <= cnt_d;
    end
  end

  // Skid buffer storage; contents are meaningless while occupancy says empty
  always_ff @(posedge clk_i) begin
    if (capture) buf_p2[tail_idx] <= fifo_data_i;
  end

`ifdef FIFO_FRAME_READER_STATS_EN
  // Completed-frame counter, wraps at 16 bits
  always_ff @(posedge clk_i) begin
    if (rst_i)                               frames_o <= 16'd0;
    else if (m_valid_o && m_ready_i && m_last_o) frames_o <= frames_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Testbench for fifo_frame_reader: FIFO model, table-driven frame vectors,
// hand sequences for latency/backpressure/reset and a randomized stream
// checked against a frame-parsing reference model.
module tb_fifo_frame_reader;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          fifo_rd_o;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i = 1'b0;
  logic          busy_o;
`ifdef FIFO_FRAME_READER_STATS_EN
  logic [15:0]   frames_o;
`endif

  always #5 clk = ~clk;

  fifo_frame_reader #(.P_DATA_WIDTH(DW), .P_LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst_i), .fifo_rd_o(fifo_rd_o), .fifo_data_i(fifo_data_i),
    .fifo_empty_i(fifo_empty_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i),
`ifdef FIFO_FRAME_READER_STATS_EN
    .frames_o(frames_o),
`endif
    .busy_o(busy_o));

  logic [DW-1:0] fq[$];   // words currently inside the upstream FIFO
  logic [DW-1:0] src[$];  // words not yet written into the FIFO
  logic [DW:0]   got[$];  // {last, data} of each handshake
  int            got_cyc[$];
  logic [DW:0]   exp_q[$];
  int            exp_frames;

  int   passed = 0, total = 0;
  int   cyc, first_rd, first_vld, rd_viol = 0, stab_viol = 0, rmode;
  logic rd_at7, prev_hold, prev_last;
  logic [DW-1:0] prev_data;

  typedef struct packed {
    int             n;
    logic [5:0][DW-1:0] w;
    int             rmode;
    int             exp_n;
  } vec_t;
  vec_t vecs [5];

  // Standard FIFO: data appears the cycle after the read strobe; reset empties it
  always @(posedge clk) begin
    if (rst_i) fq.delete();
    else if (fifo_rd_o && fq.size() != 0) fifo_data_i <= fq.pop_front();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: walk the stream as header + len payload words
  function automatic void build_exp(input logic [DW-1:0] s[$]);
    int i, len;
    exp_q.delete();
    exp_frames = 0;
    i = 0;
    while (i < s.size()) begin
      len = int'(s[i][LW-1:0]);
      if (len != 0) exp_frames++;
      for (int k = 0; k < len; k++)
        exp_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, s[i+1+k]});
      i += len + 1;
    end
  endfunction

  task automatic step();
    @(negedge clk);
    if (rmode == 0) m_ready_i = 1'b1;
    else if (rmode == 1)
      m_ready_i = !(first_rd >= 0 && cyc - first_rd >= 3 && cyc - first_rd <= 7);
    else m_ready_i = ($urandom_range(0, 3) != 0);
    if (src.size() != 0 && $urandom_range(0, 1) == 1) fq.push_back(src.pop_front());
    fifo_empty_i = (fq.size() == 0);
    #1;
    if (fifo_rd_o && fifo_empty_i) rd_viol++;
    if (prev_hold && !(m_valid_o && m_data_o == prev_data && m_last_o == prev_last)) stab_viol++;
    if (fifo_rd_o && first_rd < 0) first_rd = cyc;
    if (m_valid_o && first_vld < 0) first_vld = cyc;
    if (first_rd >= 0 && cyc - first_rd == 7) rd_at7 = fifo_rd_o;
    if (m_valid_o && m_ready_i) begin
      got.push_back({m_last_o, m_data_o});
      got_cyc.push_back(cyc);
    end
    prev_hold = m_valid_o && !m_ready_i;
    prev_data = m_data_o;
    prev_last = m_last_o;
    cyc++;
  endtask

  task automatic clear_scn();
    got.delete(); got_cyc.delete();
    cyc = 0; first_rd = -1; first_vld = -1; prev_hold = 1'b0; rd_at7 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; m_ready_i = 1'b0; fifo_empty_i = 1'b1; src.delete();
    @(negedge clk);
    rst_i = 1'b0; prev_hold = 1'b0;
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rst fifo_rd"}, fifo_rd_o, 0);
    chk({tag, " rst m_valid"}, m_valid_o, 0);
    chk({tag, " rst m_last"}, m_last_o, 0);
    chk({tag, " rst m_data"}, m_data_o, 0);
    chk({tag, " rst busy"}, busy_o, 0);
`ifdef FIFO_FRAME_READER_STATS_EN
    chk({tag, " rst frames"}, frames_o, 0);
`endif
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(src.size() == 0 && fq.size() == 0 && !busy_o && !m_valid_o) && n < budget);
    chk({tag, " finished in budget"}, n < budget, 1);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " word count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data[%0d]", tag, i), got[i][DW-1:0], exp_q[i][DW-1:0]);
      chk($sformatf("%s last[%0d]", tag, i), got[i][DW], exp_q[i][DW]);
    end
`ifdef FIFO_FRAME_READER_STATS_EN
    chk({tag, " frames_o"}, frames_o, exp_frames);
`endif
  endtask

  task automatic setv(input int v, input int n, input int rm, input int en,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input logic [DW-1:0] d, input logic [DW-1:0] e);
    vecs[v].n = n; vecs[v].rmode = rm; vecs[v].exp_n = en;
    vecs[v].w[0] = a; vecs[v].w[1] = b; vecs[v].w[2] = c;
    vecs[v].w[3] = d; vecs[v].w[4] = e; vecs[v].w[5] = '0;
  endtask

  initial begin
    logic [DW-1:0] s[$];
    logic [DW-1:0] hdr;
    int len, n;
    string tag;

    // n words, ready mode, expected output word count, stream
    setv(0, 4, 0, 3, 32'h3, 32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'h0);
    setv(1, 4, 1, 3, 32'h3, 32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'h0);
    setv(2, 5, 0, 3, 32'h2, 32'hA000_000A, 32'hB000_000B, 32'h1, 32'hC000_000C);
    setv(3, 4, 0, 2, 32'h0, 32'h2, 32'hD000_000D, 32'hE000_000E, 32'h0);
    setv(4, 2, 0, 1, 32'hABCD_0001, 32'hF000_000F, 32'h0, 32'h0, 32'h0);

    rmode = 0;
    clear_scn();
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      do_reset();
      check_reset(tag);
      clear_scn();
      rmode = vecs[v].rmode;
      s.delete();
      for (int i = 0; i < vecs[v].n; i++) s.push_back(vecs[v].w[i]);
      foreach (s[i]) fq.push_back(s[i]);
      build_exp(s);
      run_idle(tag, 200);
      chk({tag, " table count"}, got.size(), vecs[v].exp_n);
      compare(tag);
      if (v == 0) begin
        chk("latency rd->valid", first_vld - first_rd, 3);
        chk("consecutive A..C", (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[0] : -1, 2);
        chk("busy low at end", busy_o, 0);
      end
      if (v == 1) chk("no read when full", rd_at7, 0);
      if (v == 2) chk("gap B->C", (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[1] : -1, 2);
    end

    // Reset in the middle of a 4-word frame, then a fresh 1-word frame
    do_reset();
    clear_scn();
    rmode = 0;
    fq.push_back(32'h4);
    for (int i = 1; i <= 4; i++) fq.push_back(32'h5500_0000 + i);
    n = 0;
    while (got.size() < 2 && n < 50) begin
      step();
      n++;
    end
    chk("midreset reached 2 words", got.size(), 2);
    do_reset();
    check_reset("midreset");
    clear_scn();
    s.delete();
    s.push_back(32'h1);
    s.push_back(32'h6600_0066);
    foreach (s[i]) fq.push_back(s[i]);
    build_exp(s);
    run_idle("after reset", 200);
    compare("after reset");

    // Randomized frames, bursty FIFO fill, random backpressure
    do_reset();
    clear_scn();
    rmode = 2;
    s.delete();
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(0, 5);
      hdr = ($urandom() & 32'hFFFF_F000) | 32'(len);
      s.push_back(hdr);
      for (int k = 0; k < len; k++) s.push_back($urandom());
    end
    build_exp(s);
    foreach (s[i]) src.push_back(s[i]);
    run_idle("random", 5000);
    compare("random");

    chk("no read while empty", rd_viol, 0);
    chk("output stable under backpressure", stab_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
